// File: rtl/mem_write_bridge_if.sv
// Store bus from the processor plus the video-RAM handshake and status outputs of the bridge.
// The master side is the processor/video environment; the slave side is the bridge.
interface mem_write_bridge_if #(
  parameter int VRAM_WORDS = 1024
);
  localparam int IDX_W = $clog2(VRAM_WORDS);

  logic             memWr;
  logic [31:0]      direc;
  logic [31:0]      datoOut;
  logic             stall;
  logic             ramWe;
  logic             vramValid;
  logic             vramReady;
  logic [IDX_W-1:0] vramAddr;
  logic [31:0]      vramData;
  logic [7:0]       ledReg;
  logic [7:0]       dropCount;
  logic             fifoEmpty;

  modport master (
    output memWr, direc, datoOut, vramReady,
    input  stall, ramWe, vramValid, vramAddr, vramData, ledReg, dropCount, fifoEmpty
  );

  modport slave (
    input  memWr, direc, datoOut, vramReady,
    output stall, ramWe, vramValid, vramAddr, vramData, ledReg, dropCount, fifoEmpty
  );
endinterface

// File: rtl/mem_write_bridge.sv
// Decodes processor stores into data RAM writes, a queued video RAM path with stall-on-full,
// an LED/score register and a saturating drop counter.
module mem_write_bridge #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RAM_LIMIT  = 32'h0000_0400,
  parameter logic [31:0] VRAM_BASE  = 32'h0000_1000,
  parameter int          VRAM_WORDS = 1024,
  parameter logic [31:0] IO_ADDR    = 32'h0000_2000
) (
  input  logic clk,
  input  logic rst_n,
  mem_write_bridge_if.slave bus
);
  localparam int          IDX_W    = $clog2(VRAM_WORDS);
  localparam int          PTR_W    = $clog2(DEPTH);
  localparam logic [32:0] VRAM_END = {1'b0, VRAM_BASE} + 33'(VRAM_WORDS) * 33'd4;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic             in_ram, in_vram, in_io, drop;
  logic [31:0]      off;
  logic [IDX_W-1:0] idx;
  logic             unused_off;

  // Region decode in priority order: RAM, aligned VRAM window, IO register, else drop.
  assign in_ram     = bus.direc < RAM_LIMIT;
  assign in_vram    = !in_ram && (bus.direc >= VRAM_BASE) && ({1'b0, bus.direc} < VRAM_END)
                      && (bus.direc[1:0] == 2'b00);
  assign in_io      = !in_ram && !in_vram && (bus.direc == IO_ADDR);
  assign drop       = bus.memWr && !in_ram && !in_vram && !in_io;
  assign off        = bus.direc - VRAM_BASE;
  assign idx        = off[IDX_W+1:2];
  assign unused_off = ^{off[31:IDX_W+2], off[1:0]};

  logic [IDX_W-1:0] idx_mem  [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, push, pop;
  logic [7:0]       led_reg, drop_cnt;

  assign full  = count == (PTR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign push  = bus.memWr && in_vram && !full;
  assign pop   = !empty && bus.vramReady;

  // Entry storage carries no reset; emptiness is tracked by the counter alone.
  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[wr_ptr]  <= idx;
      data_mem[wr_ptr] <= bus.datoOut;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      led_reg  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.memWr && in_io) led_reg <= bus.datoOut[7:0];
      if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  assign bus.ramWe     = bus.memWr && in_ram;
  assign bus.stall     = bus.memWr && in_vram && full;
  assign bus.vramValid = !empty;
  assign bus.fifoEmpty = empty;
  assign bus.vramAddr  = empty ? '0 : idx_mem[rd_ptr];
  assign bus.vramData  = empty ? '0 : data_mem[rd_ptr];
  assign bus.ledReg    = led_reg;
  assign bus.dropCount = drop_cnt;
endmodule
